// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 stream distributor.
// One valid/ready input beat per cycle is steered by in_select to one of four
// output channels. Each channel owns a 2-entry FIFO (head + tail registers),
// so a stalled consumer only blocks beats addressed to its own channel.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (flushes all FIFOs)
//   in_data    beat payload
//   in_select  destination channel 0..3, qualified by in_valid
//   in_valid   beat present
//   in_ready   beat accepted this cycle when in_valid is high
//   out_data   channel k payload at [k*WIDTH +: WIDTH], straight from head reg
//   out_valid  bit k: channel k head entry valid
//   out_ready  bit k: consumer k takes the head this cycle
//   all_empty  all four FIFOs hold zero entries
module demux4_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_select,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic                 all_empty
);

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 2;

  logic [NCH-1:0][WIDTH-1:0] head_q, head_d;
  logic [NCH-1:0][WIDTH-1:0] tail_q, tail_d;
  logic [NCH-1:0][CW-1:0]    count_q, count_d;
  logic [NCH-1:0]            push;
  logic [NCH-1:0]            pop;

  // Ready depends only on the addressed channel's registered occupancy.
  assign in_ready  = (count_q[in_select] != CW'(2));
  assign all_empty = (count_q == '0);
  assign out_data  = head_q;

  // Valid decode from registered counts.
  always_comb begin
    out_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      out_valid[k] = (count_q[k] != '0);
    end
  end

  // Per-channel FIFO next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    push    = '0;
    pop     = '0;
    for (int k = 0; k < NCH; k++) begin
      push[k] = in_valid && in_ready && (in_select == CW'(k));
      pop[k]  = out_valid[k] && out_ready[k];
      unique case ({push[k], pop[k]})
        2'b10: begin
          if (count_q[k] == '0) begin
            head_d[k] = in_data;
          end else begin
            tail_d[k] = in_data;
          end
          count_d[k] = count_q[k] + CW'(1);
        end
        2'b01: begin
          // Tail advances into head when draining a full channel.
          if (count_q[k] == CW'(2)) begin
            head_d[k] = tail_q[k];
          end
          count_d[k] = count_q[k] - CW'(1);
        end
        2'b11: begin
          // Only reachable at count 1: new beat replaces the departing head.
          head_d[k] = in_data;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/demux4_stream.md
# demux4_stream

Registered 1-to-4 stream distributor: accepts one data beat per cycle on a single valid/ready input and steers it, by a 2-bit select sent with the beat, to one of four independent valid/ready output channels. Each channel has its own 2-entry FIFO, so a stalled consumer blocks only beats addressed to it. It is the counterpart of the 4-input select path: the pipeline uses it to fan results or requests out to four consumers, such as write-back ports or functional-unit queues.

## Interface
- WIDTH, default 8: data width of every beat.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  beat payload.
- in_select  input  2  destination channel (0..3), qualified by in_valid.
- in_valid  input  1  beat present.
- in_ready  output  1  beat accepted this cycle if in_valid is also high.
- out_data  output  4*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH].
- out_valid  output  4  bit k: channel k head entry valid.
- out_ready  input  4  bit k: consumer k takes the head this cycle.
- all_empty  output  1  all four FIFOs hold zero entries.

## Operation
- Per channel k: 2-entry FIFO (head and tail registers, count_k in 0..2).
- in_ready = (count[in_select] != 2).
  - Purely combinational from in_select and the registered counts.
  - Independent of in_valid and of out_ready (no pass-through when full).
- Push on channel k: in_valid && in_ready && in_select == k.
- Pop on channel k: out_valid[k] && out_ready[k].
- Count update per channel:
  - push only: +1.
  - pop only: −1.
  - push and pop together: count unchanged.
  - neither: hold.
- Push at count 0: beat goes to the head.
- Push at count 1 with no pop: beat goes to the tail.
- Push at count 1 with a pop: beat goes to the head.
- Pop at count 2: tail moves to head; head takes the tail value in the same edge.
- out_valid[k] = (count_k != 0).
- out_data slice k = head register of channel k, driven straight from the register (no muxing from the input).
- Per-channel order is strictly FIFO. No ordering is guaranteed across channels.
- At most one push per cycle. Pops on all four channels may occur in the same cycle.
- out_ready[k] while out_valid[k] = 0 is ignored.
- A beat is never dropped, duplicated, or misrouted. in_data/in_select with in_valid = 0 have no effect.
- all_empty = all counts zero (registered state, combinational decode).

## Timing
- Reset (rst_n low, asynchronous; takes effect without a clock edge):
  - all counts = 0, so out_valid = 4'b0000.
  - head and tail registers = 0, so out_data = 0.
  - all_empty = 1.
  - in_ready = 1.
- Release of rst_n is synchronous to clk. Normal operation resumes on the first rising edge after release.
- Latency: a beat accepted at edge N is visible on out_valid/out_data of its channel after edge N, i.e. in cycle N+1. No bypass path exists, so zero-cycle latency never occurs.
- Throughput: one beat per cycle to a channel whose consumer holds out_ready = 1 continuously. The count stays at 1.
- Full channel: in_ready = 0 only while in_select addresses that channel. Redirecting in_select to a non-full channel raises in_ready in the same cycle.
- Reset mid-operation flushes every FIFO. Beats held at assertion are lost. Beats presented during reset are not accepted.

## Test plan
- Reset: drive rst_n = 0 mid-cycle with no clock -> out_valid = 0, out_data = 0, all_empty = 1 and in_ready = 1 immediately.
- Single beat: push 0xA5 with select 2 -> cycle after acceptance out_valid = 4'b0100, slice 2 = 0xA5, all_empty = 0. Pulse out_ready[2] -> out_valid returns to 0 and all_empty = 1.
- Fill and stall on channel 0 with out_ready = 0:
  - push 0x11, 0x22 -> in_ready drops to 0 with select = 0 and the third beat 0x33 is held.
  - switch select to 1 -> in_ready = 1 and beat 0x33 lands on channel 1.
  - then release out_ready[0] -> channel 0 emits 0x11, then 0x22, in order.
- Simultaneous push/pop at count 1 on channel 3 with out_ready[3] = 1: stream 0x01..0x08 -> outputs 0x01..0x08 one per cycle, count stays 1, in_ready stays high.
- Interleaved channels, out_ready = 4'b1111: selects 0,1,2,3,0 with data 0xC0..0xC4 -> each channel receives its beats in order, one cycle after acceptance, with no cross-channel corruption.
- Reset mid-operation: channels 0 and 1 at count 2, assert rst_n low for one cycle -> all out_valid = 0 at once. After release, a new push 0x5A on channel 0 appears alone, with no stale data.
